// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, read-tracking
// state encoding and starvation counter width.
package dmem_arbiter_pkg;

    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    // Wide enough for the largest supported MAX_WAIT (15).
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD_C = 2'd1,
        ARB_RD_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Counts consecutive cycles in which the debug port asked for the memory and
// was refused; at_limit hands it priority over the CPU.
module arb_starve_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic req,
    input  logic gnt,
    output logic at_limit
);

    logic [STARVE_W-1:0] cnt;

    assign at_limit = (cnt == STARVE_W'(MAX_WAIT));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (gnt || !req) begin
            cnt <= '0;
        end else if (!at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU MEM stage (port 0) and the
// debug/loader master (port 1), with read-response routing and CPU stall.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wd,
    output logic                  c_gnt,
    output logic                  c_stall,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rd,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wd,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rd,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    arb_state_e state, state_next;
    logic       at_limit;

    // The CPU wins ties unless the debug port has been starved to the limit.
    assign c_gnt   = resetn & c_req & ~(d_req & at_limit);
    assign d_gnt   = resetn & d_req & (~c_req | at_limit);
    assign c_stall = c_req & ~c_gnt;

    arb_starve_ctr #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk     (clk),
        .resetn  (resetn),
        .req     (d_req),
        .gnt     (d_gnt),
        .at_limit(at_limit)
    );

    assign mem_addr = d_gnt ? d_addr : c_addr;
    assign mem_wd   = d_gnt ? d_wd   : c_wd;
    assign mem_we   = (c_gnt & c_we) | (d_gnt & d_we);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default is assigned first so every path drives state_next and
    // no latch is inferred.
    always_comb begin
        state_next = ARB_IDLE;
        if (c_gnt && !c_we) begin
            state_next = ARB_RD_C;
        end else if (d_gnt && !d_we) begin
            state_next = ARB_RD_D;
        end
    end

    // Both ports see the raw memory data; only the owner's rvalid qualifies it.
    assign c_rvalid = (state == ARB_RD_C);
    assign d_rvalid = (state == ARB_RD_D);
    assign c_rd     = mem_rd;
    assign d_rd     = mem_rd;

endmodule
